muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit producing a HI/LO result pair. Replaces the separate multiplier and divider and their HI/LO source muxing in the multicycle processor. It supports signed and unsigned multiply and divide through one start/done handshake, with abort and divide-by-zero reporting. The control unit starts an operation and waits for `done`; HI and LO then load from `hi`/`lo`.

## Interface
- `WIDTH`, 32: operand width; `hi`/`lo` are each `WIDTH` bits; legal range ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation, captured with `start`: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend, captured with `start`.
- `b`  in  WIDTH  multiplier / divisor, captured with `start`.
- `abort`  in  1  cancels the operation in flight.
- `busy`  out  1  high in CALC and FIXUP.
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`div_zero` are valid from this cycle.
- `hi`  out  WIDTH  product upper half / remainder.
- `lo`  out  WIDTH  product lower half / quotient.
- `div_zero`  out  1  last completed op was DIV/DIVU with `b == 0`; held until the next `done`.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE with `start`=1 and `abort`=0:
  - Capture `op`, `a`, `b`.
  - Signed ops take operand magnitudes and record the result signs.
  - Next state is CALC with the step counter at 0.
  - Exception: DIV/DIVU with `b == 0` goes straight to DONE.
- DONE without a new start returns to IDLE.
- CALC runs WIDTH iterations (counter 0..WIDTH-1), then moves to FIXUP.
  - Multiply: radix-2 shift-add over a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIXUP applies sign correction:
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
  - Then to DONE.
- `hi`/`lo`/`div_zero` registers update only on the edge entering DONE; otherwise they hold.
- Divide by zero: `hi` = `a`, `lo` = all ones, `div_zero` = 1, for both DIV and DIVU.
- Signed overflow, DIV of most-negative by −1: `lo` = most-negative, `hi` = 0, `div_zero` = 0.
- MULTU/DIVU treat operands as unsigned. MULT/DIV treat them as two's complement.
- `abort`=1 in CALC or FIXUP: next state IDLE, no `done`, `hi`/`lo`/`div_zero` unchanged.
- `abort` in IDLE/DONE blocks any `start` in the same cycle (abort wins).
- `start` during CALC/FIXUP is ignored; it is neither queued nor an error.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0; counter 0.
- Cycle 0 is the cycle in which `start` is sampled high.
- Normal op:
  - `busy`=1 in cycles 1..WIDTH+1 (CALC is 1..WIDTH, FIXUP is WIDTH+1).
  - `done`=1 in cycle WIDTH+2 (34 for WIDTH=32), with `busy`=0.
- Divide by zero: `done`=1 in cycle 1; `busy` never rises.
- Back-to-back: a `start` in the DONE cycle begins the next op; its `busy` rises the following cycle.
- Reset deasserted mid-operation: the unit resumes in IDLE with all outputs at reset values. The aborted op leaves no trace.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_t` (MULT, MULTU, DIV, DIVU encodings).
  - `muldiv_state_t` (IDLE, CALC, FIXUP, DONE).
  - Op-class helpers: `is_signed(op)`, `is_div(op)`.
- One sub-module: `muldiv_magnitude`, a combinational two's-complement conditional negate (`neg`, `in`, `out`, width parameter).
  - Used for operand absolute values at start.
  - Instantiated at 2·WIDTH width for FIXUP result negation.
- Step counter width: `$clog2(WIDTH)+1`.

## Test plan
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> `done` in cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high cycles 1..33.
- MULT `a`=−3, `b`=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULT `a`=0x80000000, `b`=0x80000000 -> `hi`=0x40000000, `lo`=0.
- Division cases:
  - DIV `a`=−7, `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU `a`=7, `b`=2 -> `lo`=3, `hi`=1.
  - DIV `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU `a`=5, `b`=0 -> `done` in cycle 1, `div_zero`=1, `hi`=5, `lo`=0xFFFFFFFF. A following MULTU 2×3 clears `div_zero` and gives `lo`=6.
- Abort and busy-start:
  - After a completed result `lo`=6, start DIV; assert `abort` in cycle 10 -> `busy`=0 in cycle 11, no `done` ever, `lo` stays 6.
  - A `start` pulsed in cycle 5 of a busy op is ignored.
- Reset and handshake edges:
  - Pull `reset` low in cycle 20 of a MULT -> all outputs 0 immediately.
  - After release, a new MULTU completes in 34 cycles.
  - Back-to-back starts in the DONE cycle work; `start`+`abort` together in IDLE does nothing.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } muldiv_state_t;

   // MULT and DIV (op[0] == 0) interpret operands as two's complement.
   function automatic logic is_signed(input muldiv_op_t op);
      return ~op[0];
   endfunction

   // DIV and DIVU share op[1] == 1.
   function automatic logic is_div(input muldiv_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_magnitude.sv
// Combinational two's-complement conditional negate.
module muldiv_magnitude #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   assign out = neg ? ((~in) + WIDTH'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit with a HI/LO result pair.
// Operands are reduced to magnitudes at start, the core runs unsigned
// shift-add or restoring division for WIDTH cycles, and FIXUP restores signs.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   muldiv_state_t      state;
   muldiv_op_t         op_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               neg_q;
   logic               neg_r;

   muldiv_op_t         op_in;
   logic               start_go;
   logic               a_neg;
   logic               b_neg;
   logic               mag_a_neg;
   logic               mag_b_neg;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;
   logic [WIDTH-1:0]   mag_a_out;
   logic [WIDTH-1:0]   mag_b_out;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign op_in    = muldiv_op_t'(op);
   assign start_go = start && !abort && ((state == IDLE) || (state == DONE));
   assign a_neg    = is_signed(op_in) && a[WIDTH-1];
   assign b_neg    = is_signed(op_in) && b[WIDTH-1];

   // The two narrow negators take operand magnitudes at start and are
   // reused in FIXUP to sign-correct quotient (lo) and remainder (hi).
   always_comb begin
      mag_a_in  = a;
      mag_a_neg = a_neg;
      mag_b_in  = b;
      mag_b_neg = b_neg;
      if (state == FIXUP) begin
         mag_a_in  = acc[WIDTH-1:0];
         mag_a_neg = neg_q;
         mag_b_in  = acc[2*WIDTH-1:WIDTH];
         mag_b_neg = neg_r;
      end
   end

   muldiv_magnitude #(.WIDTH(WIDTH)) u_mag_a (
      .neg (mag_a_neg),
      .in  (mag_a_in),
      .out (mag_a_out)
   );

   muldiv_magnitude #(.WIDTH(WIDTH)) u_mag_b (
      .neg (mag_b_neg),
      .in  (mag_b_in),
      .out (mag_b_out)
   );

   muldiv_magnitude #(.WIDTH(2*WIDTH)) u_mag_prod (
      .neg (neg_q),
      .in  (acc),
      .out (prod_fix)
   );

   // One iteration of shift-add multiply and restoring divide; acc holds
   // {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
      mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
      div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      fix_hi   = is_div(op_q) ? mag_b_out : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = is_div(op_q) ? mag_a_out : prod_fix[WIDTH-1:0];
   end

   // Datapath registers: loaded at start, stepped in CALC; no reset needed.
   always_ff @(posedge clk) begin
      if (start_go) begin
         acc   <= {{WIDTH{1'b0}}, mag_a_out};
         opb   <= mag_b_out;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (state == CALC) begin
         acc <= is_div(op_q) ? div_next : mul_next;
      end
   end

   // Control FSM with registered busy/done and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= MULT;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               state <= IDLE;
               if (start_go) begin
                  op_q <= op_in;
                  cnt  <= '0;
                  if (is_div(op_in) && (b == '0)) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     hi       <= a;
                     lo       <= '1;
                     div_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == CNT_W'(WIDTH-1)) begin
                  state <= FIXUP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIXUP: begin
               busy <= 1'b0;
               if (abort) begin
                  state <= IDLE;
               end else begin
                  state    <= DONE;
                  done     <= 1'b1;
                  hi       <= fix_hi;
                  lo       <= fix_lo;
                  div_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        abort = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int total = 0;
   int bad = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   // Drive a start for one cycle; returns just after the sampling edge (cycle 1).
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait for done starting at cycle first; counts cycles where busy was low.
   task automatic wait_done(input int first, output int cyc, output int busy_low, output logic busy_at_done);
      cyc = first;
      busy_low = 0;
      busy_at_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done) begin
            busy_at_done = busy;
            return;
         end
         if (!busy) busy_low++;
         if (cyc > 100) begin
            cyc = -1;
            return;
         end
         cyc++;
      end
   endtask

   task automatic test_reset;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_multu;
      int cyc, bl; logic bd;
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, cyc, bl, bd);
      total++; if (cyc !== 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", cyc); end
      total++; if (bl !== 0) begin bad++; $display("FAIL multu_busy_low got=%0d exp=0", bl); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b exp=0", bd); end
      total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
   endtask

   task automatic test_mult;
      int cyc, bl; logic bd;
      launch(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done(1, cyc, bl, bd);
      total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_neg got=%h exp=ffffffffffffffeb", {hi, lo}); end
      launch(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_done(1, cyc, bl, bd);
      total++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mult_minmin got=%h exp=4000000000000000", {hi, lo}); end
      total++; if (cyc !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", cyc); end
   endtask

   task automatic test_div;
      int cyc, bl; logic bd;
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, cyc, bl, bd);
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_q got=%h exp=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_r got=%h exp=ffffffff", hi); end
      total++; if (cyc !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", cyc); end
      launch(2'b11, 32'd7, 32'd2);
      wait_done(1, cyc, bl, bd);
      total++; if ({hi, lo} !== {32'd1, 32'd3}) begin bad++; $display("FAIL divu_7_2 got=%h exp=0000000100000003", {hi, lo}); end
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, cyc, bl, bd);
      total++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin bad++; $display("FAIL div_ovf got=%h exp=0000000080000000", {hi, lo}); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_ovf_dz got=%b exp=0", div_zero); end
   endtask

   task automatic test_div_zero;
      int cyc, bl; logic bd;
      launch(2'b11, 32'd5, 32'd0);
      wait_done(1, cyc, bl, bd);
      total++; if (cyc !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", cyc); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b exp=0", bd); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
      total++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL dz_hilo got=%h exp=00000005ffffffff", {hi, lo}); end
      launch(2'b01, 32'd2, 32'd3);
      wait_done(1, cyc, bl, bd);
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
      total++; if (lo !== 32'd6) begin bad++; $display("FAIL multu_2_3 got=%h exp=6", lo); end
   endtask

   task automatic test_abort;
      int seen_done;
      launch(2'b10, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      seen_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
      total++; if ({hi, lo} !== {32'd0, 32'd6}) begin bad++; $display("FAIL abort_hold got=%h exp=0000000000000006", {hi, lo}); end
   endtask

   task automatic test_busy_start;
      int cyc, bl; logic bd;
      launch(2'b01, 32'd3, 32'd5);
      repeat (5) @(negedge clk);
      op = 2'b11; a = 32'd0; b = 32'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(6, cyc, bl, bd);
      total++; if (cyc !== 34) begin bad++; $display("FAIL busy_start_latency got=%0d exp=34", cyc); end
      total++; if ({hi, lo, div_zero} !== {32'd0, 32'd15, 1'b0}) begin bad++; $display("FAIL busy_start_result got=%h exp=0000000000000000f,0", {hi, lo, div_zero}); end
   endtask

   task automatic test_reset_mid;
      int cyc, bl; logic bd;
      launch(2'b00, 32'd9, 32'd9);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if ({busy, done, div_zero} !== 3'b000) begin bad++; $display("FAIL rst_mid_ctrl got=%b exp=000", {busy, done, div_zero}); end
      total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_hilo got=%h exp=0", {hi, lo}); end
      @(negedge clk);
      reset = 1'b1;
      launch(2'b01, 32'd6, 32'd7);
      wait_done(1, cyc, bl, bd);
      total++; if (cyc !== 34) begin bad++; $display("FAIL rst_after_latency got=%0d exp=34", cyc); end
      total++; if (lo !== 32'd42) begin bad++; $display("FAIL rst_after_lo got=%h exp=2a", lo); end
   endtask

   task automatic test_back_to_back;
      int cyc, bl; logic bd;
      launch(2'b01, 32'h10, 32'h10);
      wait_done(1, cyc, bl, bd);
      total++; if (lo !== 32'h100) begin bad++; $display("FAIL b2b_first got=%h exp=100", lo); end
      op = 2'b11; a = 32'd100; b = 32'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      wait_done(2, cyc, bl, bd);
      total++; if (cyc !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", cyc); end
      total++; if ({hi, lo} !== {32'd1, 32'd11}) begin bad++; $display("FAIL b2b_second got=%h exp=000000010000000b", {hi, lo}); end
   endtask

   task automatic test_start_abort;
      int act;
      @(negedge clk);
      op = 2'b01; a = 32'd1; b = 32'd1; start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      act = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy || done) act++;
      end
      total++; if (act !== 0) begin bad++; $display("FAIL start_abort_activity got=%0d exp=0", act); end
      total++; if ({hi, lo} !== {32'd1, 32'd11}) begin bad++; $display("FAIL start_abort_hold got=%h exp=000000010000000b", {hi, lo}); end
   endtask

   initial begin
      test_reset;
      test_multu;
      test_mult;
      test_div;
      test_div_zero;
      test_abort;
      test_busy_start;
      test_reset_mid;
      test_back_to_back;
      test_start_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
